// File: rtl/div_unit.sv
// div_unit: multicycle signed restoring divider.
// Quotient goes to lo, remainder to hi. One restoring step per clock, with
// a final sign-fixup cycle. Divide by zero short-circuits straight to DONE.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             done,
    output logic             busy,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;

    logic [WIDTH-1:0] quo_r;        // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] rem_r;        // partial remainder; always < |divisor|, so WIDTH bits suffice
    logic [WIDTH-1:0] dsr_r;        // |divisor|
    logic [CW-1:0]    cnt_r;
    logic             sign_q_r;
    logic             sign_rem_r;

    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dsr_mag_s;
    logic             dsr_zero_s;
    logic [WIDTH:0]   rem_shift_s;  // one extra bit: the shifted remainder can reach 2*|divisor|-1
    logic [WIDTH:0]   trial_s;

    assign dvd_mag_s   = dividend[WIDTH-1] ? -dividend : dividend;
    assign dsr_mag_s   = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign dsr_zero_s  = (divisor == {WIDTH{1'b0}});
    assign rem_shift_s = {rem_r, quo_r[WIDTH-1]};
    assign trial_s     = rem_shift_s - {1'b0, dsr_r};

    assign done = (state_r == DONE);
    assign busy = (state_r != IDLE);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; start is only honoured from IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (dsr_zero_s) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_next_s = FIX;
                end else begin
                    state_next_s = RUN;
                end
            end
            FIX:     state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath: operand capture, restoring steps, sign fixup and result hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo_r      <= {WIDTH{1'b0}};
            rem_r      <= {WIDTH{1'b0}};
            dsr_r      <= {WIDTH{1'b0}};
            cnt_r      <= {CW{1'b0}};
            sign_q_r   <= 1'b0;
            sign_rem_r <= 1'b0;
            lo         <= {WIDTH{1'b0}};
            hi         <= {WIDTH{1'b0}};
            div_zero   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sign_q_r   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_rem_r <= dividend[WIDTH-1];
                        quo_r      <= dvd_mag_s;
                        dsr_r      <= dsr_mag_s;
                        rem_r      <= {WIDTH{1'b0}};
                        cnt_r      <= CW'(WIDTH - 1);
                        if (dsr_zero_s) begin
                            lo       <= {WIDTH{1'b1}};
                            hi       <= dividend;
                            div_zero <= 1'b1;
                        end else begin
                            div_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (trial_s[WIDTH] == 1'b0) begin
                        rem_r <= trial_s[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r <= rem_shift_s[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r - CW'(1);
                end
                FIX: begin
                    lo <= sign_q_r   ? -quo_r : quo_r;
                    hi <= sign_rem_r ? -rem_r : rem_r;
                end
                DONE: begin
                    cnt_r <= {CW{1'b0}};
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit against an arithmetic
// reference model (signed divide/modulo with the divide-by-zero and
// overflow conventions of the unit).
module tb_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        done;
    logic        busy;
    logic        div_zero;

    int n_vec;
    int n_bad;

    div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .lo       (lo),
        .hi       (hi),
        .done     (done),
        .busy     (busy),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: truncating signed division, remainder follows dividend sign.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
            z = 1'b0;
        end else begin
            q = sa / sb;
            r = sa % sb;
            z = 1'b0;
        end
    endfunction

    // One operation from an IDLE start pulse; optionally pulses start again
    // at edge inject_at (counted from the start edge E0).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, input string tag);
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        int          lat;
        int          first;
        int          ndone;
        model(a, b, eq, er, ez);
        lat   = (b == 32'd0) ? 0 : 33;
        first = -1;
        ndone = 0;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k <= lat + 3; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (inject_at >= 0 && k == inject_at - 1) begin
                start    = 1'b1;
                dividend = $urandom;
                divisor  = $urandom | 32'd1;
            end
            if (inject_at >= 0 && k == inject_at) begin
                start = 1'b0;
            end
            if (k == 0) begin
                n_vec++;
                if (busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
                end
            end
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = k;
            end
        end
        n_vec++;
        if (first != lat || ndone != 1) begin
            n_bad++;
            $display("FAIL %s done_timing: first=%0d count=%0d want first=%0d count=1",
                     tag, first, ndone, lat);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle_after: busy=%b want 0", tag, busy);
        end
        n_vec++;
        if (lo !== eq || hi !== er || div_zero !== ez) begin
            n_bad++;
            $display("FAIL %s result %h/%h: lo=%h hi=%h dz=%b want lo=%h hi=%h dz=%b",
                     tag, a, b, lo, hi, div_zero, eq, er, ez);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        #1;
        n_vec++;
        if (lo !== 32'd0 || hi !== 32'd0 || done !== 1'b0 || busy !== 1'b0 || div_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: lo=%h hi=%h done=%b busy=%b dz=%b want all 0",
                     lo, hi, done, busy, div_zero);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_op(32'd100, 32'd7, -1, "pos_pos");
        run_op(32'hFFFF_FF9C, 32'd7, -1, "neg_pos");
        run_op(32'd100, 32'hFFFF_FFF9, -1, "pos_neg");
        run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, -1, "neg_neg");
    endtask

    task automatic test_overflow();
        run_op(32'h8000_0000, 32'hFFFF_FFFF, -1, "min_div_m1");
        run_op(32'h8000_0000, 32'd1, -1, "min_div_1");
    endtask

    task automatic test_div_zero();
        run_op(32'd5, 32'd0, -1, "div_zero");
        run_op(32'd9, 32'd3, -1, "after_zero");
    endtask

    task automatic test_start_while_busy();
        run_op(32'd100, 32'd7, 10, "start_in_run");
        run_op(32'd77, 32'd5, 34, "start_on_done");
    endtask

    task automatic test_reset_abort();
        int seen;
        seen = 0;
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (lo !== 32'd0 || hi !== 32'd0 || done !== 1'b0 || busy !== 1'b0 || div_zero !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_abort: lo=%h hi=%h done=%b busy=%b dz=%b want all 0",
                     lo, hi, done, busy, div_zero);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        n_vec++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL no_done_after_abort: got %0d done cycles want 0", seen);
        end
        run_op(32'd20, 32'd6, -1, "after_abort");
    endtask

    task automatic test_hold();
        logic [31:0] eq;
        logic [31:0] er;
        logic        ez;
        logic [31:0] a;
        logic [31:0] b;
        a = $urandom;
        b = $urandom | 32'd1;
        model(a, b, eq, er, ez);
        run_op(a, b, -1, "hold_op");
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            dividend = $urandom;
            divisor  = $urandom;
            @(posedge clk);
            #1;
            n_vec++;
            if (lo !== eq || hi !== er || div_zero !== ez || done !== 1'b0) begin
                n_bad++;
                $display("FAIL hold cycle %0d: lo=%h hi=%h dz=%b done=%b want lo=%h hi=%h dz=%b done=0",
                         k, lo, hi, div_zero, done, eq, er, ez);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] qa;
        logic [31:0] ra;
        logic [31:0] qb;
        logic [31:0] rb;
        logic        za;
        logic        zb;
        logic [31:0] a2;
        logic [31:0] b2;
        int          ndone;
        a2 = $urandom;
        b2 = $urandom_range(1, 1000);
        model(32'hFFFF_FC18, 32'd33, qa, ra, za);
        model(a2, b2, qb, rb, zb);
        ndone = 0;
        @(negedge clk);
        dividend = 32'hFFFF_FC18;
        divisor  = 32'd33;
        start    = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k <= 71; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (done === 1'b1) ndone++;
            if (k == 33) begin
                n_vec++;
                if (done !== 1'b1 || lo !== qa || hi !== ra || div_zero !== za) begin
                    n_bad++;
                    $display("FAIL b2b_first: done=%b lo=%h hi=%h want done=1 lo=%h hi=%h",
                             done, lo, hi, qa, ra);
                end
                dividend = a2;
                divisor  = b2;
            end
            if (k == 34) begin
                n_vec++;
                if (busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_idle_gap: busy=%b want 0", busy);
                end
            end
            if (k == 68) begin
                n_vec++;
                if (done !== 1'b1 || lo !== qb || hi !== rb || div_zero !== zb) begin
                    n_bad++;
                    $display("FAIL b2b_second: done=%b lo=%h hi=%h want done=1 lo=%h hi=%h",
                             done, lo, hi, qb, rb);
                end
                start = 1'b0;
            end
        end
        n_vec++;
        if (ndone != 2 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_count: done cycles=%0d busy=%b want 2 and 0", ndone, busy);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 7);
            a   = $urandom;
            case (sel)
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'd1;
                3:       b = $urandom_range(1, 255);
                4:       b = -($urandom_range(1, 255));
                5:       begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom;
            endcase
            run_op(a, b, -1, "random");
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_div_zero();
        test_start_while_busy();
        test_reset_abort();
        test_hold();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
